// File: rtl/uart_pkg.sv
// Shared types and parameter-legality helpers for the UART transmit/receive blocks.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_e;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    function automatic bit fifo_depth_ok(input int unsigned depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic bit framer_params_ok(input int unsigned data_bits,
                                            input int unsigned oversample,
                                            input int unsigned fifo_depth);
        return (data_bits >= 5) && (data_bits <= 9) && (oversample >= 2) &&
               fifo_depth_ok(fifo_depth);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with flop-based storage; read data is the head entry, so a word
// written in one cycle is first visible on rd_data in the next.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    if (!fifo_depth_ok(DEPTH)) begin : g_bad_depth
        $error("uart_sync_fifo: DEPTH must be a power of two and >= 2");
    end

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push;
    logic             pop;

    assign level   = wr_ptr_q - rd_ptr_q;
    assign empty   = (level == '0);
    assign full    = (level == (AW + 1)'(DEPTH));
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter: buffers host words in a FIFO and serialises them LSB-first with
// optional parity and one or two stop bits, frames back-to-back.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_BITS-1:0]          s_data,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_two_stop,
    output logic                          tx,
    output logic                          busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned TickW = $clog2(2 * OVERSAMPLE);
    localparam int unsigned BitW  = $clog2(DATA_BITS);
    localparam logic [TickW-1:0] LastTick1 = TickW'(OVERSAMPLE - 1);
    localparam logic [TickW-1:0] LastTick2 = TickW'(2 * OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  LastBit   = BitW'(DATA_BITS - 1);

    if (!framer_params_ok(DATA_BITS, OVERSAMPLE, FIFO_DEPTH)) begin : g_bad_params
        $error("uart_tx_framer: illegal DATA_BITS, OVERSAMPLE or FIFO_DEPTH");
    end

    tx_state_e            state_q, state_d;
    logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic                 two_stop_q, two_stop_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rd_data;
    logic                 pop;
    logic                 start_frame;
    logic                 bit_last;

    assign s_ready = !fifo_full && !rst;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (s_valid && s_ready),
        .wr_data (s_data),
        .full    (fifo_full),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign bit_last = (tick_cnt_q == LastTick1);

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_en_d    = par_en_q;
        par_bit_d   = par_bit_q;
        two_stop_d  = two_stop_q;
        tx_d        = tx_q;
        done_d      = 1'b0;
        start_frame = 1'b0;

        if (tick) begin
            unique case (state_q)
                StIdle: begin
                    start_frame = !fifo_empty;
                end
                StStart: begin
                    if (bit_last) begin
                        state_d    = StData;
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        tx_d       = shift_q[0];
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
                StData: begin
                    if (bit_last) begin
                        tick_cnt_d = '0;
                        if (bit_cnt_q == LastBit) begin
                            state_d = par_en_q ? StParity : StStop;
                            tx_d    = par_en_q ? par_bit_q : 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BitW'(1);
                            shift_d   = shift_q >> 1;
                            tx_d      = shift_q[1];
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
                StParity: begin
                    if (bit_last) begin
                        state_d    = StStop;
                        tick_cnt_d = '0;
                        tx_d       = 1'b1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
                StStop: begin
                    if (tick_cnt_q == (two_stop_q ? LastTick2 : LastTick1)) begin
                        done_d      = 1'b1;
                        tick_cnt_d  = '0;
                        start_frame = !fifo_empty;
                        if (fifo_empty) state_d = StIdle;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    tx_d    = 1'b1;
                end
            endcase
        end

        // Frame start is shared by IDLE and the back-to-back path out of STOP.
        if (start_frame) begin
            state_d    = StStart;
            tick_cnt_d = '0;
            shift_d    = fifo_rd_data;
            par_en_d   = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
            par_bit_d  = (^fifo_rd_data) ^ (cfg_parity == PAR_ODD);
            two_stop_d = cfg_two_stop;
            tx_d       = 1'b0;
        end
    end

    assign pop = start_frame;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    assign tx         = tx_q;
    assign frame_done = done_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: OVERSAMPLE=4, DATA_BITS=8, FIFO_DEPTH=8, tick every 2 clk.
module tb_uart_tx_framer;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic [1:0] cfg_parity;
    logic       cfg_two_stop;
    logic       tx;
    logic       busy;
    logic       frame_done;
    logic [3:0] fifo_level;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_framer #(
        .DATA_BITS  (8),
        .OVERSAMPLE (4),
        .FIFO_DEPTH (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .cfg_parity   (cfg_parity),
        .cfg_two_stop (cfg_two_stop),
        .tx           (tx),
        .busy         (busy),
        .frame_done   (frame_done),
        .fifo_level   (fifo_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One tick period: tick high across one rising edge, low across the next.
    // Returns at the falling edge right after the tick edge.
    task automatic step();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, output logic accepted);
        @(negedge clk);
        s_valid  = 1'b1;
        s_data   = d;
        accepted = s_ready;
        @(negedge clk);
        s_valid  = 1'b0;
    endtask

    // bits[0] is the start bit; step 1 is the tick that launches the start bit.
    task automatic run_frame(input logic [10:0] bits, input int nbits, input bit chained,
                             input bit flip_cfg, input string tag);
        for (int k = 1; k <= nbits * 4; k++) begin
            step();
            if (k == 1 && flip_cfg) cfg_parity = ~cfg_parity;
            check({tag, "/tx"}, 32'(tx), 32'(bits[(k - 1) / 4]));
            check({tag, "/done"}, 32'(frame_done), 32'(k == 1 && chained));
            check({tag, "/busy"}, 32'(busy), 32'(1));
        end
    endtask

    task automatic finish_frame(input string tag);
        step();
        check({tag, "/done_end"}, 32'(frame_done), 32'(1));
        check({tag, "/tx_end"}, 32'(tx), 32'(1));
        check({tag, "/busy_end"}, 32'(busy), 32'(0));
        step();
        check({tag, "/done_clr"}, 32'(frame_done), 32'(0));
        check({tag, "/tx_idle"}, 32'(tx), 32'(1));
    endtask

    initial begin
        logic acc;

        rst          = 1'b1;
        tick         = 1'b0;
        s_valid      = 1'b0;
        s_data       = '0;
        cfg_parity   = 2'b00;
        cfg_two_stop = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst/tx", 32'(tx), 32'(1));
        check("rst/busy", 32'(busy), 32'(0));
        check("rst/done", 32'(frame_done), 32'(0));
        check("rst/level", 32'(fifo_level), 32'(0));
        check("rst/ready", 32'(s_ready), 32'(0));
        rst = 1'b0;
        @(negedge clk);
        check("rst/ready_after", 32'(s_ready), 32'(1));

        // Idle line with empty FIFO
        step();
        check("idle/tx", 32'(tx), 32'(1));
        check("idle/busy", 32'(busy), 32'(0));

        // Basic frame: 0xA5, no parity, 1 stop
        push(8'hA5, acc);
        check("basic/acc", 32'(acc), 32'(1));
        check("basic/level", 32'(fifo_level), 32'(1));
        run_frame({1'b0, 1'b1, 8'hA5, 1'b0}, 10, 1'b0, 1'b0, "basic");
        finish_frame("basic");

        // Even parity on 0x07 -> parity 1; config flipped mid-frame must be ignored
        cfg_parity = 2'b01;
        push(8'h07, acc);
        run_frame({1'b1, 1'b1, 8'h07, 1'b0}, 11, 1'b0, 1'b1, "even");
        finish_frame("even");

        // Odd parity on 0x07 -> parity 0
        check("odd/cfg", 32'(cfg_parity), 32'(2));
        push(8'h07, acc);
        run_frame({1'b1, 1'b0, 8'h07, 1'b0}, 11, 1'b0, 1'b0, "odd");
        finish_frame("odd");

        // Two stop bits on 0x00, no parity
        cfg_parity   = 2'b11;
        cfg_two_stop = 1'b1;
        push(8'h00, acc);
        run_frame({2'b11, 8'h00, 1'b0}, 11, 1'b0, 1'b0, "stop2");
        finish_frame("stop2");

        // Back-to-back frames, no idle gap
        cfg_parity   = 2'b00;
        cfg_two_stop = 1'b0;
        push(8'h11, acc);
        push(8'h22, acc);
        push(8'h33, acc);
        check("b2b/level", 32'(fifo_level), 32'(3));
        run_frame({1'b0, 1'b1, 8'h11, 1'b0}, 10, 1'b0, 1'b0, "b2b1");
        run_frame({1'b0, 1'b1, 8'h22, 1'b0}, 10, 1'b1, 1'b0, "b2b2");
        run_frame({1'b0, 1'b1, 8'h33, 1'b0}, 10, 1'b1, 1'b0, "b2b3");
        finish_frame("b2b");

        // FIFO full with tick held low
        for (int i = 0; i < 9; i++) begin
            push(8'(i + 1), acc);
            check($sformatf("full/acc%0d", i), 32'(acc), 32'(i < 8));
        end
        check("full/level", 32'(fifo_level), 32'(8));
        check("full/ready", 32'(s_ready), 32'(0));
        check("full/busy", 32'(busy), 32'(0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("full/level_rst", 32'(fifo_level), 32'(0));
        @(negedge clk);
        check("full/ready_rst", 32'(s_ready), 32'(1));

        // Mid-frame reset with 3 words queued behind the active one
        push(8'h11, acc);
        push(8'h22, acc);
        push(8'h33, acc);
        push(8'h44, acc);
        for (int k = 1; k <= 17; k++) begin
            step();
            check("mrst/nodone", 32'(frame_done), 32'(0));
        end
        check("mrst/level_pre", 32'(fifo_level), 32'(3));
        check("mrst/busy_pre", 32'(busy), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        check("mrst/tx", 32'(tx), 32'(1));
        check("mrst/busy", 32'(busy), 32'(0));
        check("mrst/level", 32'(fifo_level), 32'(0));
        check("mrst/done", 32'(frame_done), 32'(0));
        rst = 1'b0;
        for (int k = 0; k < 50; k++) begin
            step();
            check("mrst/tx_idle", 32'(tx), 32'(1));
            check("mrst/done_idle", 32'(frame_done), 32'(0));
            check("mrst/busy_idle", 32'(busy), 32'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

Parameterised UART transmitter with an input FIFO, runtime-selectable parity (none/even/odd) and stop-bit count (1/2), and configurable data width and oversampling ratio. It accepts bytes from the host side over a valid/ready stream, buffers them, and serialises them LSB-first onto `tx`. Frames go out back-to-back with no idle gap. It sits between the host/bus logic and the pad, driven by the shared baud-tick generator.

## Interface
- `DATA_BITS`, 8: data bits per frame; legal range 5–9.
- `OVERSAMPLE`, 16: `tick` pulses per bit period; must be ≥ 2.
- `FIFO_DEPTH`, 8: input FIFO entries; must be a power of two and ≥ 2.

Ports:
- `clk`  in  1  single clock; everything is synchronous to its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tick`  in  1  baud×OVERSAMPLE enable; one-`clk` pulse.
- `s_valid`  in  1  host word valid.
- `s_ready`  out  1  FIFO can accept a word.
- `s_data`  in  DATA_BITS  host word.
- `cfg_parity`  in  2  parity mode: 00 none, 01 even, 10 odd, 11 none.
- `cfg_two_stop`  in  1  0 selects 1 stop bit; 1 selects 2 stop bits.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  a frame is in progress (FSM is not IDLE).
- `frame_done`  out  1  one-`clk` pulse when a frame's last stop tick completes.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of words in the FIFO.

## Operation
Reset values:
- `tx`=1, `busy`=0, `frame_done`=0, `fifo_level`=0.
- `s_ready`=0 while `rst` is high, 1 in the first cycle after reset.
- FIFO pointers cleared; any stored words are discarded.

FIFO:
- Push when `s_valid && s_ready`.
- `s_ready` = not full.
- No fall-through: a word pushed in cycle N is visible to the FSM from cycle N+1.
- Push and pop may happen in the same cycle at any level except empty. When empty, only the push happens; when full, no push is possible.

FSM states: IDLE, START, DATA, PARITY, STOP. State advances only on `clk` edges where `tick`=1.
- **IDLE**: `tx`=1. On a tick with the FIFO non-empty: pop the word into the shift register, latch `cfg_parity` and `cfg_two_stop`, compute parity, drive `tx`=0, go to START.
- **START**: hold `tx`=0 for OVERSAMPLE ticks, then go to DATA.
- **DATA**: output `shift[0]` for OVERSAMPLE ticks per bit, shifting right after each bit; DATA_BITS bits total. Then go to PARITY if parity is enabled, otherwise to STOP.
- **PARITY**: output the parity bit for OVERSAMPLE ticks. Even parity = XOR of the data bits; odd parity = the inverse of that.
- **STOP**: `tx`=1 for OVERSAMPLE ticks (1 stop bit) or 2×OVERSAMPLE ticks (2 stop bits).
  - On the final stop tick, pulse `frame_done`.
  - If the FIFO is non-empty on that tick, pop the next word and enter START directly (`tx`=0 on the same edge).
  - Otherwise go to IDLE.

Counters and width rules:
- `tick_cnt` is $clog2(2×OVERSAMPLE) bits wide. It resets to 0 at every bit boundary and never exceeds 2×OVERSAMPLE−1.
- `bit_cnt` is $clog2(DATA_BITS) bits wide. It resets to 0 on entry to DATA.

Boundary behaviour:
- Configuration inputs are sampled only at frame start; changes mid-frame have no effect on the current frame.
- `rst` takes priority over `tick`, push and pop.
- Reset mid-frame: `tx`=1 at the next edge, no `frame_done` pulse, FIFO emptied.
- Between ticks, all state and outputs hold.

## Timing
- Push to start bit: the start bit begins on the first tick at or after cycle N+1 (word pushed in cycle N, FSM in IDLE).
- Frame length in ticks = OVERSAMPLE × (1 + DATA_BITS + parity + stop bits), where parity is 0 or 1 and stop bits is 1 or 2.
- `tx` is registered and changes only on tick edges (or on reset).
- `frame_done` is registered and coincides with the edge that leaves STOP.
- `busy` rises on the start-bit edge. It falls on the edge that leaves STOP to IDLE, and stays high across back-to-back frames.

## Structure
- `uart_pkg`: `parity_e` enum (`PAR_NONE`, `PAR_EVEN`, `PAR_ODD`), `tx_state_e` enum, parameter-legality checks as elaboration-time assertions.
- Sub-module `uart_sync_fifo` (parameters: WIDTH, DEPTH): registered read, full/empty/level outputs. It is reused by the future receive path.
- The FSM, counters and shift register live in `uart_tx_framer`.

## Test plan
Benches use OVERSAMPLE=4, DATA_BITS=8, FIFO_DEPTH=8, with `tick` every 2 `clk` cycles unless stated otherwise.
1. **Basic frame**: push 0xA5, no parity, 1 stop -> `tx` bits 0,1,0,1,0,0,1,0,1,1, each held 4 ticks; one `frame_done` pulse after 40 ticks; `busy` low afterwards.
2. **Parity**: push 0x07 with even parity -> parity bit 1; push 0x07 with odd parity -> parity bit 0; each frame is 44 ticks.
3. **Two stop bits**: push 0x00, no parity, 2 stop -> stop high for 8 ticks; `frame_done` at tick 44.
4. **FIFO full**: `tick`=0, push 9 words -> `s_ready` low after the 8th accepted word; `fifo_level`=8; the 9th word is not accepted.
5. **Back-to-back**: push 0x11, 0x22, 0x33 with continuous ticks -> start bits immediately follow stop bits with no idle gap; three `frame_done` pulses exactly 40 ticks apart; `busy` high throughout.
6. **Mid-frame reset**: assert `rst` at tick 17 with 3 words queued -> next cycle `tx`=1, `busy`=0, `fifo_level`=0; no `frame_done` pulse; `tx` stays idle afterwards.
